opb_master_arb: RTL and testbench
=================================

// Module: opb_master_arb
// PURPOSE
//  Two-requester arbiter/sequencer for the single OPB master port on SYS_CLK.
//  Port 0 is the UART command server's bus path; port 1 is a second internal master (status poller/DMA).
//  Serialises word read/write requests onto OPB_ADDR/OPB_DO/OPB_RE/OPB_WE.
//  Captures OPB_DI after a fixed read latency. Returns data and a one-cycle ACK to the winner.
// PARAMETERS
//  RD_LATENCY  2   cycles from the OPB_RE cycle to the cycle OPB_DI is sampled; legal range 1..15
// PORTS
//  SYS_CLK   in   1   system clock, 100 MHz; all logic on its rising edge
//  SYS_RST   in   1   reset, asynchronous, active-high
//  M0_REQ    in   1   port 0 request; held high until M0_ACK is seen
//  M0_WE     in   1   port 0 direction: 1 = write, 0 = read; stable while M0_REQ is high
//  M0_ADDR   in   32  port 0 word address; stable while M0_REQ is high
//  M0_WDATA  in   32  port 0 write data; stable while M0_REQ is high
//  M0_ACK    out  1   one-cycle pulse: port 0 transaction complete
//  M0_RDATA  out  32  port 0 read data; valid from the M0_ACK cycle onward
//  M1_REQ/M1_WE/M1_ADDR/M1_WDATA/M1_ACK/M1_RDATA   same as port 0, for port 1
//  OPB_ADDR  out  32  bus address
//  OPB_DO    out  32  bus write data
//  OPB_DI    in   32  bus read data
//  OPB_RE    out  1   read strobe, one cycle
//  OPB_WE    out  1   write strobe, one cycle
//  BUSY      out  1   high whenever the FSM is not in IDLE
// BEHAVIOUR
//  Reset values: all outputs 0. FSM = IDLE. Latency counter = 0. last_grant = 1, so port 0 wins the first tie.
//  All outputs are registered; no combinational path from inputs to outputs.
//  FSM states: IDLE -> ISSUE -> (read: WAIT_RD) -> DONE -> IDLE.
//  IDLE
//   - REQ inputs are sampled only in IDLE.
//   - If any REQ is high: grant by round-robin. With both high, grant the port not equal to last_grant.
//   - Latch the grant, WE, ADDR and WDATA, update last_grant, and go to ISSUE.
//  ISSUE (one cycle)
//   - OPB_ADDR = latched ADDR; OPB_DO = latched WDATA on writes.
//   - Exactly one of OPB_WE / OPB_RE is 1.
//   - Next state: write -> DONE; read -> WAIT_RD.
//  WAIT_RD
//   - Counts cycles. OPB_DI is captured into the granted Mx_RDATA at the end of the cycle
//     RD_LATENCY cycles after the ISSUE cycle.
//   - Then go to DONE.
//  DONE (one cycle)
//   - Granted Mx_ACK = 1, then return to IDLE.
//   - The requester clears REQ on the edge that samples ACK, so IDLE sees REQ low.
//   - A REQ still high in IDLE is a new request.
//  Latency, with REQ first seen in IDLE at cycle c:
//   - Strobe in cycle c+1.
//   - Write ACK in cycle c+2.
//   - Read ACK in cycle c+2+RD_LATENCY.
//   - Minimum gap is one IDLE cycle between transactions.
//  OPB_ADDR and OPB_DO hold their last values between transactions.
//  Mx_RDATA changes only on that port's read completion; writes leave it unchanged.
//  Ungranted port: its REQ stays pending and its ACK stays 0.
//   - With both ports requesting continuously, grants alternate strictly 0,1,0,1.
//  REQ dropped before ACK (protocol violation): the latched transaction still completes and ACK still pulses.
//  Input changes on the granted port after the grant have no effect; the latched copies are used.
//  Reset mid-transaction:
//   - All outputs drop to 0 asynchronously, the FSM returns to IDLE, and no ACK is issued.
//   - A requester still holding REQ after reset is re-served from IDLE.
// TESTING
//  1. Port 0 write (M0_WE=1, M0_ADDR=AABBCCDD, M0_WDATA=11223344)
//     -> OPB_WE high one cycle with OPB_ADDR=AABBCCDD, OPB_DO=11223344; M0_ACK 2 cycles after REQ is sampled; OPB_RE, M1_ACK stay 0.
//  2. Port 1 read (M1_ADDR=12345678, RD_LATENCY=2, OPB_DI=12345678 driven)
//     -> OPB_RE one cycle; M1_RDATA=12345678; M1_ACK at cycle c+4; M0_RDATA stays 0.
//  3. Both REQ raised together after reset and held (4 transactions)
//     -> grant order 0,1,0,1; never two ACKs in the same cycle.
//  4. Port 0 issues back-to-back reads, port 1 idle
//     -> every request served; exactly one IDLE cycle between ACK and the next strobe; BUSY low only in that cycle.
//  5. SYS_RST pulsed while in WAIT_RD
//     -> OPB_RE/WE, ACKs and RDATA all 0 immediately, no ACK for the aborted read; held REQ completes normally after release.
//  6. Sweep RD_LATENCY = 1 and 15
//     -> read ACK at c+3 and c+17 respectively; captured data equals OPB_DI from the required sample cycle.

Source files
------------

// File: rtl/opb_master_arb.sv
// Two-port round-robin sequencer for the single OPB master port.
// Each granted word transaction runs IDLE -> ISSUE -> (WAIT_RD) -> DONE with fully registered outputs.
module opb_master_arb #(
    parameter int unsigned RD_LATENCY = 2
) (
    input  logic        SYS_CLK,
    input  logic        SYS_RST,
    input  logic        M0_REQ,
    input  logic        M0_WE,
    input  logic [31:0] M0_ADDR,
    input  logic [31:0] M0_WDATA,
    output logic        M0_ACK,
    output logic [31:0] M0_RDATA,
    input  logic        M1_REQ,
    input  logic        M1_WE,
    input  logic [31:0] M1_ADDR,
    input  logic [31:0] M1_WDATA,
    output logic        M1_ACK,
    output logic [31:0] M1_RDATA,
    output logic [31:0] OPB_ADDR,
    output logic [31:0] OPB_DO,
    input  logic [31:0] OPB_DI,
    output logic        OPB_RE,
    output logic        OPB_WE,
    output logic        BUSY
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, DONE} state_t;

    localparam logic [3:0] LAT = 4'(RD_LATENCY);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        last_grant_q, last_grant_d;
    logic        grant_q, grant_d;
    logic        we_q, we_d;
    logic [31:0] opb_addr_q, opb_addr_d;
    logic [31:0] opb_do_q, opb_do_d;
    logic        opb_re_q, opb_re_d;
    logic        opb_we_q, opb_we_d;
    logic        ack0_q, ack0_d;
    logic        ack1_q, ack1_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        busy_q, busy_d;
    logic        sel;

    always_comb begin
        // NOTE: every _d gets a default before the case, so no path can infer a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        opb_addr_d   = opb_addr_q;
        opb_do_d     = opb_do_q;
        opb_re_d     = 1'b0;
        opb_we_d     = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        sel          = 1'b0;

        case (state_q)
            IDLE: begin
                if (M0_REQ || M1_REQ) begin
                    // A tie goes to the port that did not win last time.
                    sel          = (M0_REQ && M1_REQ) ? ~last_grant_q : M1_REQ;
                    grant_d      = sel;
                    last_grant_d = sel;
                    we_d         = sel ? M1_WE : M0_WE;
                    opb_addr_d   = sel ? M1_ADDR : M0_ADDR;
                    if (we_d) begin
                        opb_do_d = sel ? M1_WDATA : M0_WDATA;
                        opb_we_d = 1'b1;
                    end else begin
                        opb_re_d = 1'b1;
                    end
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                end else begin
                    state_d = WAIT_RD;
                    cnt_d   = 4'd1;
                end
            end
            WAIT_RD: begin
                // cnt_q counts cycles since the strobe; OPB_DI is valid on the last one.
                if (cnt_q == LAT) begin
                    if (grant_q) rdata1_d = OPB_DI;
                    else         rdata0_d = OPB_DI;
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    cnt_d   = 4'd0;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments only; every flop, read data included, is reset.
    always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
        if (SYS_RST) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            opb_addr_q   <= 32'd0;
            opb_do_q     <= 32'd0;
            opb_re_q     <= 1'b0;
            opb_we_q     <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            rdata0_q     <= 32'd0;
            rdata1_q     <= 32'd0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            opb_addr_q   <= opb_addr_d;
            opb_do_q     <= opb_do_d;
            opb_re_q     <= opb_re_d;
            opb_we_q     <= opb_we_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
            busy_q       <= busy_d;
        end
    end

    assign OPB_ADDR = opb_addr_q;
    assign OPB_DO   = opb_do_q;
    assign OPB_RE   = opb_re_q;
    assign OPB_WE   = opb_we_q;
    assign M0_ACK   = ack0_q;
    assign M1_ACK   = ack1_q;
    assign M0_RDATA = rdata0_q;
    assign M1_RDATA = rdata1_q;
    assign BUSY     = busy_q;

endmodule

// File: tb/tb_opb_master_arb.sv
// Bench for opb_master_arb: directed scenarios plus randomized traffic scored against a
// transaction-timing model (grant cycle -> strobe, capture and ACK cycles by arithmetic).
module tb_opb_master_arb;

    localparam int L = 2;

    typedef struct {
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          gap;
    } txn_t;

    logic        SYS_CLK = 1'b0;
    logic        SYS_RST = 1'b1;
    logic        M0_REQ = 1'b0, M0_WE = 1'b0, M1_REQ = 1'b0, M1_WE = 1'b0;
    logic [31:0] M0_ADDR = '0, M0_WDATA = '0, M1_ADDR = '0, M1_WDATA = '0, OPB_DI = '0;

    logic        M0_ACK, M1_ACK, OPB_RE, OPB_WE, BUSY;
    logic [31:0] M0_RDATA, M1_RDATA, OPB_ADDR, OPB_DO;

    logic        a1_m0_ack, a1_m1_ack, a1_re, a1_we, a1_busy;
    logic [31:0] a1_m0_rdata, a1_m1_rdata, a1_addr, a1_do;
    logic        a15_m0_ack, a15_m1_ack, a15_re, a15_we, a15_busy;
    logic [31:0] a15_m0_rdata, a15_m1_rdata, a15_addr, a15_do;

    opb_master_arb #(.RD_LATENCY(L)) dut (
        .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST),
        .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
        .M0_ACK(M0_ACK), .M0_RDATA(M0_RDATA),
        .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
        .M1_ACK(M1_ACK), .M1_RDATA(M1_RDATA),
        .OPB_ADDR(OPB_ADDR), .OPB_DO(OPB_DO), .OPB_DI(OPB_DI),
        .OPB_RE(OPB_RE), .OPB_WE(OPB_WE), .BUSY(BUSY)
    );

    opb_master_arb #(.RD_LATENCY(1)) dut_l1 (
        .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST),
        .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
        .M0_ACK(a1_m0_ack), .M0_RDATA(a1_m0_rdata),
        .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
        .M1_ACK(a1_m1_ack), .M1_RDATA(a1_m1_rdata),
        .OPB_ADDR(a1_addr), .OPB_DO(a1_do), .OPB_DI(OPB_DI),
        .OPB_RE(a1_re), .OPB_WE(a1_we), .BUSY(a1_busy)
    );

    opb_master_arb #(.RD_LATENCY(15)) dut_l15 (
        .SYS_CLK(SYS_CLK), .SYS_RST(SYS_RST),
        .M0_REQ(M0_REQ), .M0_WE(M0_WE), .M0_ADDR(M0_ADDR), .M0_WDATA(M0_WDATA),
        .M0_ACK(a15_m0_ack), .M0_RDATA(a15_m0_rdata),
        .M1_REQ(M1_REQ), .M1_WE(M1_WE), .M1_ADDR(M1_ADDR), .M1_WDATA(M1_WDATA),
        .M1_ACK(a15_m1_ack), .M1_RDATA(a15_m1_rdata),
        .OPB_ADDR(a15_addr), .OPB_DO(a15_do), .OPB_DI(OPB_DI),
        .OPB_RE(a15_re), .OPB_WE(a15_we), .BUSY(a15_busy)
    );

    initial forever #5 SYS_CLK = ~SYS_CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Requester side: pending transactions per port and the one currently presented.
    txn_t rq [2][$];
    txn_t cur [2];
    bit   req [2];
    bit   rst_req;
    bit   di_force;
    logic [31:0] di_val;
    logic [31:0] di_hist [int];
    int   m;

    // Reference model: the single transaction in flight, described by its key cycles.
    bit          pv;
    int          p_port, p_grant, p_issue, p_ack;
    bit          p_we;
    logic [31:0] p_addr, p_wdata, p_rd;
    int          free_at;
    int          last_grant;
    logic [31:0] m_addr, m_do;
    logic [31:0] m_rdata [2];
    bit          e_ack [2];

    int          ack_log [$];
    int          ack0_count;
    bit          sweep_on;
    int          sweep_c, t1, t15;
    logic [31:0] r1, r15;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, obs, exp, m);
        end
    endtask

    task automatic model_reset();
        pv         = 1'b0;
        m_addr     = '0;
        m_do       = '0;
        m_rdata[0] = '0;
        m_rdata[1] = '0;
        last_grant = 1;
    endtask

    task automatic check_outputs();
        check("opb_re",   OPB_RE,   pv && (m == p_issue) && !p_we);
        check("opb_we",   OPB_WE,   pv && (m == p_issue) && p_we);
        check("opb_addr", OPB_ADDR, m_addr);
        check("opb_do",   OPB_DO,   m_do);
        check("busy",     BUSY,     pv && (m >= p_issue) && (m <= p_ack));
        check("m0_ack",   M0_ACK,   e_ack[0]);
        check("m1_ack",   M1_ACK,   e_ack[1]);
        check("m0_rdata", M0_RDATA, m_rdata[0]);
        check("m1_rdata", M1_RDATA, m_rdata[1]);
    endtask

    task automatic push(input int p, input bit we, input logic [31:0] addr,
                        input logic [31:0] wdata, input int gap);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.gap = gap;
        rq[p].push_back(t);
    endtask

    // One clock cycle: check outputs of cycle m, then drive inputs sampled at its closing edge.
    task automatic step();
        txn_t t;
        int   g;
        bit   scr0, scr1;
        @(negedge SYS_CLK);
        if (pv && m == p_issue) begin
            m_addr = p_addr;
            if (p_we) m_do = p_wdata;
        end
        if (pv && m == p_ack && !p_we) m_rdata[p_port] = p_rd;
        for (int p = 0; p < 2; p++) e_ack[p] = pv && (m == p_ack) && (p_port == p);
        check_outputs();

        if (M0_ACK) begin ack_log.push_back(0); ack0_count++; end
        if (M1_ACK) ack_log.push_back(1);
        if (sweep_on) begin
            if (a1_m0_ack && t1 < 0)   begin t1 = m;  r1 = a1_m0_rdata;   end
            if (a15_m0_ack && t15 < 0) begin t15 = m; r15 = a15_m0_rdata; end
        end

        if (rst_req != SYS_RST) begin
            SYS_RST = rst_req;
            if (rst_req) begin
                model_reset();
                e_ack[0] = 1'b0;
                e_ack[1] = 1'b0;
                #1;
                check_outputs();
            end else begin
                free_at = m;
            end
        end

        for (int p = 0; p < 2; p++) begin
            if (req[p] && e_ack[p]) req[p] = 1'b0;
            if (!req[p] && rq[p].size() > 0) begin
                t = rq[p][0];
                if (t.gap == 0) begin
                    cur[p] = t;
                    void'(rq[p].pop_front());
                    req[p] = 1'b1;
                end else begin
                    t.gap--;
                    rq[p][0] = t;
                end
            end
        end

        // The granted port's pins are scrambled while its transaction is in flight.
        scr0 = pv && p_port == 0 && m > p_grant && m < p_ack;
        scr1 = pv && p_port == 1 && m > p_grant && m < p_ack;
        M0_REQ   = req[0];
        M0_WE    = scr0 ? 1'($urandom) : cur[0].we;
        M0_ADDR  = scr0 ? $urandom     : cur[0].addr;
        M0_WDATA = scr0 ? $urandom     : cur[0].wdata;
        M1_REQ   = req[1];
        M1_WE    = scr1 ? 1'($urandom) : cur[1].we;
        M1_ADDR  = scr1 ? $urandom     : cur[1].addr;
        M1_WDATA = scr1 ? $urandom     : cur[1].wdata;
        OPB_DI   = di_force ? di_val : $urandom;
        di_hist[m] = OPB_DI;

        if (!SYS_RST) begin
            if (pv && !p_we && m == p_issue + L) p_rd = OPB_DI;
            if (m >= free_at && (req[0] || req[1])) begin
                g = (req[0] && req[1]) ? 1 - last_grant : (req[1] ? 1 : 0);
                last_grant = g;
                pv      = 1'b1;
                p_port  = g;
                p_we    = cur[g].we;
                p_addr  = cur[g].addr;
                p_wdata = cur[g].wdata;
                p_grant = m;
                p_issue = m + 1;
                p_ack   = p_we ? m + 2 : m + 2 + L;
                free_at = p_ack + 1;
                if (sweep_on && sweep_c < 0) sweep_c = m;
            end
        end
        m++;
    endtask

    task automatic run_until_idle(input int budget, input string tag);
        int k = 0;
        while (k < budget && !(rq[0].size() == 0 && rq[1].size() == 0 &&
                               !req[0] && !req[1] && m >= free_at)) begin
            step();
            k++;
        end
        check(tag, k < budget, 1);
    endtask

    task automatic pulse_reset();
        rst_req = 1'b1;
        step();
        step();
        rst_req = 1'b0;
    endtask

    initial begin
        int k;
        model_reset();
        m = 0; free_at = 0; rst_req = 1'b1; di_force = 1'b0; di_val = '0;
        req[0] = 1'b0; req[1] = 1'b0; sweep_on = 1'b0;
        cur[0] = '{1'b0, 32'd0, 32'd0, 0};
        cur[1] = '{1'b0, 32'd0, 32'd0, 0};
        repeat (3) step();
        rst_req = 1'b0;

        // Port 0 write.
        push(0, 1'b1, 32'hAABBCCDD, 32'h11223344, 1);
        run_until_idle(50, "t1_done");

        // Port 1 read with a fixed bus value.
        di_force = 1'b1; di_val = 32'h12345678;
        push(1, 1'b0, 32'h12345678, $urandom, 0);
        run_until_idle(50, "t2_done");
        di_force = 1'b0;

        // Both ports raised together after reset and held: 0,1,0,1.
        pulse_reset();
        ack_log.delete();
        for (int i = 0; i < 2; i++) begin
            push(0, 1'($urandom), $urandom, $urandom, 0);
            push(1, 1'($urandom), $urandom, $urandom, 0);
        end
        run_until_idle(100, "t3_done");
        check("t3_ack_count", ack_log.size(), 4);
        for (int i = 0; i < 4; i++)
            check("t3_grant_order", (i < ack_log.size()) ? ack_log[i] : 99, i % 2);

        // Back-to-back reads on port 0.
        ack0_count = 0;
        for (int i = 0; i < 4; i++) push(0, 1'b0, $urandom, $urandom, 0);
        run_until_idle(100, "t4_done");
        check("t4_ack_count", ack0_count, 4);

        // Reset while the read is in WAIT_RD; the held request is served again afterwards.
        ack0_count = 0;
        push(0, 1'b0, 32'hCAFE0000, $urandom, 0);
        k = 0;
        while (!(pv && m == p_issue + 1) && k < 50) begin step(); k++; end
        check("t5_reach_wait", k < 50, 1);
        pulse_reset();
        run_until_idle(100, "t5_done");
        check("t5_ack_count", ack0_count, 1);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            push(0, 1'($urandom), $urandom, $urandom, $urandom_range(0, 3));
            push(1, 1'($urandom), $urandom, $urandom, $urandom_range(0, 3));
        end
        run_until_idle(4000, "rand_done");

        // Latency sweep on the RD_LATENCY=1 and 15 instances.
        pulse_reset();
        sweep_on = 1'b1; sweep_c = -1; t1 = -1; t15 = -1; r1 = '0; r15 = '0;
        push(0, 1'b0, 32'h0000BEEF, $urandom, 0);
        repeat (25) step();
        check("sweep_grant_seen", sweep_c >= 0, 1);
        check("l1_ack_cycle",  t1,  sweep_c + 3);
        check("l1_rdata",      r1,  di_hist.exists(sweep_c + 2)  ? di_hist[sweep_c + 2]  : 32'hX);
        check("l15_ack_cycle", t15, sweep_c + 17);
        check("l15_rdata",     r15, di_hist.exists(sweep_c + 16) ? di_hist[sweep_c + 16] : 32'hX);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
